// File: rtl/tdm_demux1x8_pkg.sv
// Shared constants and state encoding for the 1-to-8 TDM demultiplexer.
package tdm_demux1x8_pkg;

  localparam int LANES  = 8;
  localparam int SLOT_W = 3;

  // Auto-mode frame collector states.
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux1x8_if.sv
// Lane bus of the TDM demultiplexer: serial input side plus the eight-lane output word.
interface tdm_demux1x8_if
  import tdm_demux1x8_pkg::*;
#(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0]       din;
  logic                   din_valid;
  logic                   frame_sync;
  logic                   mode;
  logic [SLOT_W-1:0]      s;
  logic [LANES*WIDTH-1:0] o;
  logic [SLOT_W-1:0]      slot;
  logic                   frame_done;
  logic                   drop;
  logic                   busy;

  // Sample source: drives the serial lane and control, watches the lane word.
  modport master (
    output din, din_valid, frame_sync, mode, s,
    input  o, slot, frame_done, drop, busy
  );

  // Demultiplexer side.
  modport slave (
    input  din, din_valid, frame_sync, mode, s,
    output o, slot, frame_done, drop, busy
  );

endinterface

// File: rtl/tdm_demux1x8_lane_write_dec.sv
// Gated 3-to-8 one-hot write-enable decoder, shared by shadow and manual lane writes.
module tdm_demux1x8_lane_write_dec
  import tdm_demux1x8_pkg::*;
(
  input  logic              en,
  input  logic [SLOT_W-1:0] idx,
  output logic [LANES-1:0]  we
);

  // One-hot enable for lane idx when en is high, all zero otherwise.
  always_comb begin
    // NOTE: default every output before the conditional write so no latch is inferred.
    we = '0;
    if (en) we[idx] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux1x8.sv
// Sequential 1-to-8 demultiplexer: round-robin TDM frames (auto) or direct lane select (manual).
module tdm_demux1x8
  import tdm_demux1x8_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  tdm_demux1x8_if.slave bus
);

  state_t            state;
  logic [SLOT_W-1:0] slot_q;
  logic [WIDTH-1:0]  shadow [LANES];
  logic [WIDTH-1:0]  lane_q [LANES];
  logic              frame_done_q;
  logic              drop_q;

  logic              shadow_en;
  logic [SLOT_W-1:0] shadow_idx;
  logic [LANES-1:0]  shadow_we;
  logic              manual_en;
  logic [LANES-1:0]  manual_we;

  // Auto mode writes the shadow on a sync (lane 0) or on any sample while collecting.
  assign shadow_en  = !bus.mode && bus.din_valid && (bus.frame_sync || state == COLLECT);
  assign shadow_idx = bus.frame_sync ? '0 : slot_q;
  assign manual_en  = bus.mode && bus.din_valid;

  tdm_demux1x8_lane_write_dec u_shadow_dec (
    .en  (shadow_en),
    .idx (shadow_idx),
    .we  (shadow_we)
  );

  tdm_demux1x8_lane_write_dec u_manual_dec (
    .en  (manual_en),
    .idx (bus.s),
    .we  (manual_we)
  );

  // Frame collector FSM with shadow buffer, lane output register and event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      slot_q       <= '0;
      frame_done_q <= 1'b0;
      drop_q       <= 1'b0;
      // NOTE: shadow is a handful of flops, not a RAM, so it is reset with the rest of the state.
      for (int k = 0; k < LANES; k++) begin
        shadow[k] <= '0;
        lane_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout; later writes in this block override the defaults.
      frame_done_q <= 1'b0;
      drop_q       <= 1'b0;
      if (bus.mode) begin
        // Manual mode: abandon any partial frame and write the selected lane directly.
        if (state == COLLECT) drop_q <= 1'b1;
        state  <= IDLE;
        slot_q <= '0;
        for (int k = 0; k < LANES; k++) begin
          shadow[k] <= '0;
          if (manual_we[k]) lane_q[k] <= bus.din;
        end
      end else if (bus.din_valid) begin
        for (int k = 0; k < LANES; k++) begin
          if (shadow_we[k])        shadow[k] <= bus.din;
          else if (bus.frame_sync) shadow[k] <= '0;
        end
        if (bus.frame_sync) begin
          // Start (or restart) a frame; a restart throws away the partial one.
          if (state == COLLECT) drop_q <= 1'b1;
          state  <= COLLECT;
          slot_q <= SLOT_W'(1);
        end else if (state == IDLE) begin
          // Unsynced sample: nothing to attach it to.
          drop_q <= 1'b1;
        end else if (slot_q == SLOT_W'(LANES - 1)) begin
          // Last slot: publish the whole frame at once so lanes never mix frames.
          for (int k = 0; k < LANES - 1; k++) lane_q[k] <= shadow[k];
          lane_q[LANES-1] <= bus.din;
          frame_done_q    <= 1'b1;
          slot_q          <= '0;
          state           <= IDLE;
        end else begin
          slot_q <= slot_q + 1'b1;
        end
      end
    end
  end

  // Flatten the lane registers onto the output word, lane 0 in the low bits.
  always_comb begin
    bus.o = '0;
    for (int k = 0; k < LANES; k++) bus.o[k*WIDTH +: WIDTH] = lane_q[k];
  end

  assign bus.slot       = slot_q;
  assign bus.frame_done = frame_done_q;
  assign bus.drop       = drop_q;
  assign bus.busy       = (state == COLLECT);

endmodule

// File: tb/tb_tdm_demux1x8.sv
// Self-checking bench for tdm_demux1x8 at WIDTH=1 and WIDTH=4 against a frame-level model.
module tb_tdm_demux1x8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_demux1x8_if #(.WIDTH(1)) if_a ();
  tdm_demux1x8_if #(.WIDTH(4)) if_b ();

  tdm_demux1x8 #(.WIDTH(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  tdm_demux1x8 #(.WIDTH(4)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: index 0 = WIDTH 1 instance, index 1 = WIDTH 4 instance.
  // m_cnt = samples gathered in the current frame (0 = no frame open).
  logic [31:0] m_o    [2];
  logic [3:0]  m_buf  [2][8];
  int          m_cnt  [2];
  bit          m_fd   [2];
  bit          m_drop [2];

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      m_o[id] = '0; m_cnt[id] = 0; m_fd[id] = 0; m_drop[id] = 0;
      for (int k = 0; k < 8; k++) m_buf[id][k] = '0;
    end
  endtask

  task automatic model_step(int id, int w, bit v, bit fs, bit md, logic [2:0] sel, logic [3:0] d);
    m_fd[id] = 0; m_drop[id] = 0;
    if (md) begin
      if (m_cnt[id] != 0) m_drop[id] = 1;
      m_cnt[id] = 0;
      if (v) for (int b = 0; b < w; b++) m_o[id][int'(sel) * w + b] = d[b];
    end else if (v) begin
      if (fs) begin
        if (m_cnt[id] != 0) m_drop[id] = 1;
        m_buf[id][0] = d;
        m_cnt[id] = 1;
      end else if (m_cnt[id] == 0) begin
        m_drop[id] = 1;
      end else begin
        m_buf[id][m_cnt[id]] = d;
        m_cnt[id]++;
        if (m_cnt[id] == 8) begin
          m_o[id] = '0;
          for (int k = 0; k < 8; k++)
            for (int b = 0; b < w; b++) m_o[id][k * w + b] = m_buf[id][k][b];
          m_fd[id] = 1;
          m_cnt[id] = 0;
        end
      end
    end
  endtask

  function automatic logic [13:0] exp_a();
    return {m_o[0][7:0], m_cnt[0][2:0], m_fd[0], m_drop[0], m_cnt[0] != 0};
  endfunction

  function automatic logic [13:0] got_a();
    return {if_a.o, if_a.slot, if_a.frame_done, if_a.drop, if_a.busy};
  endfunction

  function automatic logic [37:0] exp_b();
    return {m_o[1], m_cnt[1][2:0], m_fd[1], m_drop[1], m_cnt[1] != 0};
  endfunction

  function automatic logic [37:0] got_b();
    return {if_b.o, if_b.slot, if_b.frame_done, if_b.drop, if_b.busy};
  endfunction

  // Drive one cycle on instance A at the falling edge, sample 1 ns after the rising edge.
  task automatic step_a(bit v, bit fs, bit md, logic [2:0] sel, logic d);
    @(negedge clk);
    if_a.din_valid = v; if_a.frame_sync = fs; if_a.mode = md; if_a.s = sel; if_a.din = d;
    @(posedge clk);
    #1;
    model_step(0, 1, v, fs, md, sel, {3'b000, d});
  endtask

  task automatic step_b(bit v, bit fs, bit md, logic [2:0] sel, logic [3:0] d);
    @(negedge clk);
    if_b.din_valid = v; if_b.frame_sync = fs; if_b.mode = md; if_b.s = sel; if_b.din = d;
    @(posedge clk);
    #1;
    model_step(1, 4, v, fs, md, sel, d);
  endtask

  task automatic idle_inputs();
    if_a.din_valid = 0; if_a.frame_sync = 0; if_a.mode = 0; if_a.s = '0; if_a.din = '0;
    if_b.din_valid = 0; if_b.frame_sync = 0; if_b.mode = 0; if_b.s = '0; if_b.din = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #12;
    n_total++;
    if (got_a() !== 14'h0) $display("FAIL reset_a: got %h want %h", got_a(), 14'h0);
    else n_pass++;
    n_total++;
    if (got_b() !== 38'h0) $display("FAIL reset_b: got %h want %h", got_b(), 38'h0);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_auto_frame();
    logic [7:0] pat = 8'b01001101;
    int fd_seen = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step_a(1, i == 0, 0, '0, pat[i]);
      fd_seen += int'(if_a.frame_done);
      n_total++;
      if (got_a() !== exp_a()) $display("FAIL auto_frame[%0d]: got %h want %h", i, got_a(), exp_a());
      else n_pass++;
    end
    n_total++;
    if (if_a.o !== 8'b01001101 || if_a.slot !== 3'd0 || fd_seen != 1)
      $display("FAIL auto_frame_end: got o=%b slot=%0d fd_count=%0d want o=01001101 slot=0 fd_count=1",
               if_a.o, if_a.slot, fd_seen);
    else n_pass++;
  endtask

  task automatic test_gaps();
    logic [7:0] pat = 8'b01001101;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i != 0) for (int g = 0; g < 3; g++) begin
        step_a(0, 0, 0, '0, 1'b1);
        n_total++;
        if (got_a() !== exp_a() || if_a.o !== 8'h00)
          $display("FAIL gaps_hold[%0d.%0d]: got %h want %h", i, g, got_a(), exp_a());
        else n_pass++;
      end
      step_a(1, i == 0, 0, '0, pat[i]);
      n_total++;
      if (got_a() !== exp_a()) $display("FAIL gaps[%0d]: got %h want %h", i, got_a(), exp_a());
      else n_pass++;
    end
    n_total++;
    if (if_a.o !== 8'b01001101) $display("FAIL gaps_end: got o=%b want 01001101", if_a.o);
    else n_pass++;
  endtask

  task automatic test_resync();
    int fd_seen = 0;
    bit drop_at_resync = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step_a(1, i == 0, 0, '0, 1'(i));
      fd_seen += int'(if_a.frame_done);
    end
    for (int i = 0; i < 8; i++) begin
      step_a(1, i == 0, 0, '0, 1'b1);
      fd_seen += int'(if_a.frame_done);
      if (i == 0) drop_at_resync = if_a.drop;
      n_total++;
      if (got_a() !== exp_a()) $display("FAIL resync[%0d]: got %h want %h", i, got_a(), exp_a());
      else n_pass++;
    end
    n_total++;
    if (if_a.o !== 8'hFF || !drop_at_resync || fd_seen != 1)
      $display("FAIL resync_end: got o=%h drop=%b fd_count=%0d want o=ff drop=1 fd_count=1",
               if_a.o, drop_at_resync, fd_seen);
    else n_pass++;
  endtask

  task automatic test_manual();
    int fd_seen = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step_a(1, k[0], 1, 3'(k), k == 0);
      fd_seen += int'(if_a.frame_done);
      n_total++;
      if (got_a() !== exp_a()) $display("FAIL manual[%0d]: got %h want %h", k, got_a(), exp_a());
      else n_pass++;
      if (k == 0) begin
        n_total++;
        if (if_a.o !== 8'h01) $display("FAIL manual_latency: got o=%b want 00000001", if_a.o);
        else n_pass++;
      end
    end
    n_total++;
    if (if_a.o !== 8'b00000001 || fd_seen != 0)
      $display("FAIL manual_end: got o=%b fd_count=%0d want o=00000001 fd_count=0", if_a.o, fd_seen);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) step_a(1, i == 0, 0, '0, 1'b1);
    n_total++;
    if (got_a() !== exp_a()) $display("FAIL async_pre: got %h want %h", got_a(), exp_a());
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (if_a.o !== 8'h00 || if_a.slot !== 3'd0 || if_a.busy !== 1'b0)
      $display("FAIL async_reset: got o=%h slot=%0d busy=%b want o=00 slot=0 busy=0",
               if_a.o, if_a.slot, if_a.busy);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) step_a(1, i == 0, 0, '0, 1'(i % 3 == 0));
    n_total++;
    if (got_a() !== exp_a() || if_a.o !== 8'b01001001)
      $display("FAIL async_after: got %h want %h", got_a(), exp_a());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int fd_seen = 0;
    logic [7:0] pa = 8'hA5;
    logic [7:0] pb = 8'h3C;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        step_a(1, i == 0, 0, '0, (f == 0) ? pa[i] : pb[i]);
        fd_seen += int'(if_a.frame_done);
        n_total++;
        if (got_a() !== exp_a()) $display("FAIL b2b[%0d.%0d]: got %h want %h", f, i, got_a(), exp_a());
        else n_pass++;
      end
    end
    n_total++;
    if (if_a.o !== 8'h3C || fd_seen != 2)
      $display("FAIL b2b_end: got o=%h fd_count=%0d want o=3c fd_count=2", if_a.o, fd_seen);
    else n_pass++;
  endtask

  task automatic test_mode_switch();
    do_reset();
    for (int i = 0; i < 8; i++) step_a(1, i == 0, 0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step_a(1, i == 0, 0, '0, 1'b0);
    step_a(0, 0, 1, '0, 1'b0);
    n_total++;
    if (got_a() !== exp_a() || if_a.drop !== 1'b1 || if_a.o !== 8'hFF)
      $display("FAIL mode_switch: got %h want %h", got_a(), exp_a());
    else n_pass++;
    step_a(1, 0, 0, '0, 1'b0);
    n_total++;
    if (got_a() !== exp_a() || if_a.drop !== 1'b1)
      $display("FAIL mode_back_idle: got %h want %h", got_a(), exp_a());
    else n_pass++;
  endtask

  task automatic test_width4();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step_b(1, i == 0, 0, '0, 4'(i));
      n_total++;
      if (got_b() !== exp_b()) $display("FAIL w4[%0d]: got %h want %h", i, got_b(), exp_b());
      else n_pass++;
    end
    n_total++;
    if (if_b.o !== 32'h76543210) $display("FAIL w4_frame: got o=%h want 76543210", if_b.o);
    else n_pass++;
    step_b(1, 0, 0, '0, 4'hE);
    n_total++;
    if (if_b.drop !== 1'b1 || if_b.o !== 32'h76543210 || got_b() !== exp_b())
      $display("FAIL w4_unsynced: got drop=%b o=%h want drop=1 o=76543210", if_b.drop, if_b.o);
    else n_pass++;
    step_b(0, 0, 0, '0, 4'h0);
  endtask

  task automatic test_random();
    bit md_a = 0;
    bit md_b = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 25 == 0) md_a = ($urandom_range(0, 3) == 0);
      step_a($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, md_a,
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      n_total++;
      if (got_a() !== exp_a()) $display("FAIL rand_a[%0d]: got %h want %h", i, got_a(), exp_a());
      else n_pass++;
    end
    for (int i = 0; i < 300; i++) begin
      if (i % 25 == 0) md_b = ($urandom_range(0, 3) == 0);
      step_b($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, md_b,
             3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      n_total++;
      if (got_b() !== exp_b()) $display("FAIL rand_b[%0d]: got %h want %h", i, got_b(), exp_b());
      else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_auto_frame();
    test_gaps();
    test_resync();
    test_manual();
    test_async_reset();
    test_back_to_back();
    test_mode_switch();
    test_width4();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
